mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 57 +++++
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl_mfc_timer.sv | 26 ++
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// strobe bit positions and the per-state strobe decode.
package mem_access_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_MAR  = 4'd1,
    ST_LOAD_MDR  = 4'd2,
    ST_MEM_REQ   = 4'd3,
    ST_RELEASE   = 4'd4,
    ST_MDR_LATCH = 4'd5,
    ST_MDR_OUT   = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  localparam int unsigned NUM_STROBES  = 9;
  localparam int unsigned SB_BUS_DRIVE = 0;
  localparam int unsigned SB_MAR_LOAD  = 1;
  localparam int unsigned SB_MDR_WRITE = 2;
  localparam int unsigned SB_MDR_READ  = 3;
  localparam int unsigned SB_MDR_OUT   = 4;
  localparam int unsigned SB_MEM_EN    = 5;
  localparam int unsigned SB_BUSY      = 6;
  localparam int unsigned SB_DONE      = 7;
  localparam int unsigned SB_ERR       = 8;

  typedef logic [NUM_STROBES-1:0] strobe_t;

  // Strobes that are high while the controller sits in state s.
  function automatic strobe_t strobes_for(state_t s);
    strobe_t sb;
    sb = '0;
    sb[SB_BUSY] = (s != ST_IDLE);
    case (s)
      ST_LOAD_MAR: begin
        sb[SB_BUS_DRIVE] = 1'b1;
        sb[SB_MAR_LOAD]  = 1'b1;
      end
      ST_LOAD_MDR: begin
        sb[SB_BUS_DRIVE] = 1'b1;
        sb[SB_MDR_WRITE] = 1'b1;
      end
      ST_MEM_REQ:   sb[SB_MEM_EN]   = 1'b1;
      ST_MDR_LATCH: sb[SB_MDR_READ] = 1'b1;
      ST_MDR_OUT:   sb[SB_MDR_OUT]  = 1'b1;
      ST_DONE:      sb[SB_DONE]     = 1'b1;
      ST_ERR: begin
        sb[SB_DONE] = 1'b1;
        sb[SB_ERR]  = 1'b1;
      end
      default: ;
    endcase
    return sb;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/bus/memory-strobe bundle between a requester and mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          req;
  logic          rw;
  logic [DW-1:0] addrIn;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] busIn;
  logic          MFC;
  logic [DW-1:0] busOut;
  logic          busDrive;
  logic          marLoad;
  logic          mdrWriteEn;
  logic          mdrReadEn;
  logic          mdrOutEn;
  logic          memRW;
  logic          memEN;
  logic [DW-1:0] rdData;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  req, rw, addrIn, dataIn, busIn, MFC,
    output busOut, busDrive, marLoad, mdrWriteEn, mdrReadEn, mdrOutEn,
           memRW, memEN, rdData, busy, done, err
  );

  modport master (
    output req, rw, addrIn, dataIn, busIn, MFC,
    input  busOut, busDrive, marLoad, mdrWriteEn, mdrReadEn, mdrOutEn,
           memRW, memEN, rdData, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl_mfc_timer.sv
// Cycle counter bounding how long the controller may wait on MFC.
module mfc_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // count holds cycles already spent, so this is the TIMEOUT-th waiting cycle.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences a MAR/MDR/MEM access over a shared bus; Moore FSM with all
// outputs registered from the next state.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DW      = 16
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
  import mem_access_ctrl_pkg::*;

  state_t        state;
  state_t        next_state;
  logic          rw_q;
  logic [DW-1:0] data_q;
  logic          timer_en;
  logic          expired;

  strobe_t       sb_next;
  logic [DW-1:0] bus_out_next;
  logic          mem_rw_next;
  strobe_t       sb_q;
  logic [DW-1:0] bus_out_q;
  logic          mem_rw_q;
  logic [DW-1:0] rd_data;

  assign timer_en = (state == ST_MEM_REQ) || (state == ST_RELEASE);

  mfc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!timer_en),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Timeout wins over an MFC edge arriving in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (bus.req) next_state = ST_LOAD_MAR;
      ST_LOAD_MAR:  next_state = rw_q ? ST_MEM_REQ : ST_LOAD_MDR;
      ST_LOAD_MDR:  next_state = ST_MEM_REQ;
      ST_MEM_REQ: begin
        if (expired)      next_state = ST_ERR;
        else if (bus.MFC) next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (expired)       next_state = ST_ERR;
        else if (!bus.MFC) next_state = rw_q ? ST_MDR_LATCH : ST_DONE;
      end
      ST_MDR_LATCH: next_state = ST_MDR_OUT;
      ST_MDR_OUT:   next_state = ST_DONE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // LOAD_MAR is only entered from IDLE, so the address comes straight off the input.
  always_comb begin
    sb_next      = strobes_for(next_state);
    bus_out_next = '0;
    mem_rw_next  = 1'b0;
    case (next_state)
      ST_LOAD_MAR:            bus_out_next = bus.addrIn;
      ST_LOAD_MDR:            bus_out_next = data_q;
      ST_MEM_REQ, ST_RELEASE: mem_rw_next  = rw_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q      <= '0;
      bus_out_q <= '0;
      mem_rw_q  <= 1'b0;
      rw_q      <= 1'b0;
      data_q    <= '0;
      rd_data   <= '0;
    end else begin
      sb_q      <= sb_next;
      bus_out_q <= bus_out_next;
      mem_rw_q  <= mem_rw_next;
      if (state == ST_IDLE && bus.req) begin
        rw_q   <= bus.rw;
        data_q <= bus.dataIn;
      end
      if (state == ST_MDR_OUT) rd_data <= bus.busIn;
    end
  end

  assign bus.busOut     = bus_out_q;
  assign bus.busDrive   = sb_q[SB_BUS_DRIVE];
  assign bus.marLoad    = sb_q[SB_MAR_LOAD];
  assign bus.mdrWriteEn = sb_q[SB_MDR_WRITE];
  assign bus.mdrReadEn  = sb_q[SB_MDR_READ];
  assign bus.mdrOutEn   = sb_q[SB_MDR_OUT];
  assign bus.memEN      = sb_q[SB_MEM_EN];
  assign bus.memRW      = mem_rw_q;
  assign bus.rdData     = rd_data;
  assign bus.busy       = sb_q[SB_BUSY];
  assign bus.done       = sb_q[SB_DONE];
  assign bus.err        = sb_q[SB_ERR];

endmodule
